imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle MIPS core and its instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, writes them into instruction memory from byte address 0, and holds the core in reset until the load completes. The CPU top instantiates it and drives the core's reset input from `cpu_reset`.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 32-bit
// instruction words, writes them from address 0 and holds the core in reset until done.
module imem_loader #(
  parameter int MAX_WORDS = 128,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [7:0]       countHi;
  logic [CNT_W-1:0] wordCount;
  logic [CNT_W-1:0] wordIdx;
  logic [CNT_W-1:0] hdrCount;
  logic [CNT_W-1:0] nextWordIdx;
  logic [1:0]       byteIdx;
  logic [23:0]      wordReg;
  logic             accept;

  // Outputs are pure decodes of the registered state, so no input reaches them combinationally.
  assign byte_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign imem_we     = (state == WRITE);
  assign cpu_reset   = (state != DONE);
  assign done        = (state == DONE);
  assign error       = (state == ERR);

  assign accept      = byte_valid && byte_ready;
  assign hdrCount    = CNT_W'({countHi, byte_data});
  assign nextWordIdx = wordIdx + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      countHi      <= '0;
      wordCount    <= '0;
      wordIdx      <= '0;
      byteIdx      <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= HDR_HI;
        end
        HDR_HI: begin
          if (accept) begin
            countHi <= byte_data;
            state   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            wordCount <= hdrCount;
            if (hdrCount == '0) begin
              state <= DONE;
            end else if (hdrCount > CNT_W'(MAX_WORDS)) begin
              state <= ERR;
            end else begin
              byteIdx      <= '0;
              wordIdx      <= '0;
              words_loaded <= '0;
              state        <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            byteIdx <= byteIdx + 2'd1;
            // Fourth byte completes the word: latch address and data for the WRITE cycle.
            if (byteIdx == 2'd3) begin
              imem_addr  <= 32'({wordIdx, 2'b00});
              imem_wdata <= {wordReg, byte_data};
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          wordIdx      <= nextWordIdx;
          words_loaded <= words_loaded + CNT_W'(1);
          state        <= (nextWordIdx == wordCount) ? DONE : DATA;
        end
        DONE: begin
          if (start) state <= HDR_HI;
        end
        ERR: begin
          if (start) state <= HDR_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Upper three bytes of the word in flight; the last byte goes straight into imem_wdata.
  always_ff @(posedge clk) begin
    if (state == DATA && accept) wordReg <= {wordReg[15:0], byte_data};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions plus random word streams,
// checked against an instruction-memory model built from the stream contents.
module tb_imem_loader;
  localparam int MAX_WORDS = 128;
  localparam int CNT_W     = 16;
  localparam int LIMIT     = 4000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic             cpu_reset;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  // Instruction memory as the core would see it.
  logic [31:0] tbMem [MAX_WORDS];
  int weCount = 0;
  int clash   = 0;
  int badAddr = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      weCount <= weCount + 1;
      if (byte_ready) clash <= clash + 1;
      if (imem_addr[1:0] != 2'b00 || imem_addr >= 32'(MAX_WORDS * 4)) badAddr <= badAddr + 1;
      else tbMem[imem_addr[8:2]] <= imem_wdata;
    end
  end

  logic [31:0] expMem [MAX_WORDS];
  logic [31:0] wordsQ [$];
  int expWl = 0;
  int expWe = 0;
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkMem(input string tag);
    int mm;
    mm = 0;
    for (int i = 0; i < MAX_WORDS; i++) if (tbMem[i] !== expMem[i]) mm++;
    chk({tag, ".mem"}, 32'(mm), 32'd0);
  endtask

  task automatic fillWords(input int n);
    wordsQ.delete();
    for (int i = 0; i < n; i++) wordsQ.push_back($urandom);
  endtask

  // One load session; stopAfter >= 0 abandons the stream after that many accepted bytes.
  task automatic runSession(input string tag, input int n, input int gapMode, input int stopAfter);
    logic [7:0]  s [$];
    logic [15:0] hdr;
    logic        acc;
    int          idx, budget, nBytes, cycles, writes;
    logic        valid;
    hdr = 16'(n);
    valid = (n > 0) && (n <= MAX_WORDS);
    s.push_back(hdr[15:8]);
    s.push_back(hdr[7:0]);
    if (n <= MAX_WORDS) begin
      for (int i = 0; i < n; i++) begin
        s.push_back(wordsQ[i][31:24]);
        s.push_back(wordsQ[i][23:16]);
        s.push_back(wordsQ[i][15:8]);
        s.push_back(wordsQ[i][7:0]);
      end
    end
    nBytes = (stopAfter >= 0) ? stopAfter : s.size();

    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    chkBit({tag, ".startCpuReset"}, cpu_reset, 1'b1);
    chkBit({tag, ".startReady"}, byte_ready, 1'b1);
    chkBit({tag, ".startDone"}, done, 1'b0);
    chkBit({tag, ".startError"}, error, 1'b0);

    idx = 0;
    budget = 0;
    while (idx < nBytes && budget < LIMIT) begin
      case (gapMode)
        0: byte_valid = 1'b1;
        1: byte_valid = (budget % 2 == 0);
        default: begin
          byte_valid = 1'($urandom_range(0, 1));
          start      = 1'($urandom_range(0, 1));
        end
      endcase
      byte_data = s[idx];
      acc = byte_valid && byte_ready;
      tick();
      cycles++;
      budget++;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    byte_data  = 8'($urandom);

    if (stopAfter < 0) begin
      while (!done && !error && budget < LIMIT) begin
        tick();
        cycles++;
        budget++;
      end
    end
    chkBit({tag, ".inTime"}, budget < LIMIT, 1'b1);

    if (valid) begin
      writes = (stopAfter >= 0) ? (stopAfter - 2) / 4 : n;
      for (int i = 0; i < writes; i++) expMem[i] = wordsQ[i];
      expWe += writes;
      expWl = writes;
    end

    if (stopAfter < 0) begin
      if (gapMode == 0) chk({tag, ".cycles"}, 32'(cycles), 32'(3 + 5 * (n <= MAX_WORDS ? n : 0)));
      chkBit({tag, ".done"}, done, n <= MAX_WORDS);
      chkBit({tag, ".error"}, error, n > MAX_WORDS);
      chkBit({tag, ".cpuReset"}, cpu_reset, n > MAX_WORDS);
      chkBit({tag, ".ready"}, byte_ready, 1'b0);
      chkBit({tag, ".we"}, imem_we, 1'b0);
      chk({tag, ".wordsLoaded"}, 32'(words_loaded), 32'(expWl));
    end
    chk({tag, ".weCount"}, 32'(weCount), 32'(expWe));
    chk({tag, ".weWhileReady"}, 32'(clash), 32'd0);
    chk({tag, ".badAddr"}, 32'(badAddr), 32'd0);
    checkMem(tag);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tick();
    tick();
    chkBit("rst.cpuReset", cpu_reset, 1'b1);
    chkBit("rst.ready", byte_ready, 1'b0);
    chkBit("rst.we", imem_we, 1'b0);
    chkBit("rst.done", done, 1'b0);
    chkBit("rst.error", error, 1'b0);
    chk("rst.wordsLoaded", 32'(words_loaded), 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk("rst.wdata", imem_wdata, 32'd0);
    reset = 1'b0;
    tick();
    chkBit("idle.ignoresValid", byte_ready, 1'b0);

    // Nominal stream 00 02 20 08 00 05 AC 09 00 04.
    wordsQ.delete();
    wordsQ.push_back(32'h20080005);
    wordsQ.push_back(32'hAC090004);
    runSession("nominal", 2, 0, -1);
    chk("nominal.word0", tbMem[0], 32'h20080005);
    chk("nominal.word1", tbMem[1], 32'hAC090004);

    runSession("gaps", 2, 1, -1);

    fillWords(1);
    runSession("reloadDone", 1, 0, -1);

    runSession("ovf129", 129, 0, -1);
    byte_valid = 1'b1;
    repeat (3) tick();
    byte_valid = 1'b0;
    chkBit("ovf.readyLow", byte_ready, 1'b0);
    chkBit("ovf.errorHeld", error, 1'b1);
    chkBit("ovf.cpuResetHeld", cpu_reset, 1'b1);
    fillWords(1);
    runSession("afterErr", 1, 0, -1);

    runSession("ovf256", 256, 1, -1);

    // Abandon the session two bytes into word 1.
    fillWords(3);
    runSession("midWord", 3, 0, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expWl = 0;
    chkBit("midRst.ready", byte_ready, 1'b0);
    chkBit("midRst.cpuReset", cpu_reset, 1'b1);
    chkBit("midRst.done", done, 1'b0);
    chk("midRst.wordsLoaded", 32'(words_loaded), 32'd0);
    checkMem("midRst");

    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chkBit("rstWins.a", byte_ready, 1'b0);
    tick();
    chkBit("rstWins.b", byte_ready, 1'b0);

    runSession("zero", 0, 0, -1);

    fillWords(3);
    runSession("reload3", 3, 1, -1);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 16));
      fillWords(n);
      runSession("rand", n, int'($urandom_range(0, 2)), -1);
    end

    fillWords(MAX_WORDS);
    runSession("maxWords", MAX_WORDS, 0, -1);

    runSession("zeroKeeps", 0, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
